etx_arbiter: RTL and testbench



---
 rtl/etx_arb_pkg.sv | 44 ++++
 rtl/oh_arbiter_rr.sv | 66 ++++++
 rtl/etx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_etx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etx_arb_pkg.sv
// -----------------------------------------------------------------------------
// etx_arb_pkg
// Shared definitions for the elink TX arbiter:
//   - emesh packet field bit positions
//   - requester index constants (wr / rd / rr)
//   - arbiter FSM state encoding
//   - next_req(): round-robin successor of a requester index
// Build option used by etx_arbiter: ETX_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
package etx_arb_pkg;

  // emesh packet layout
  localparam int PKT_WRITE_BIT    = 0;
  localparam int PKT_DATAMODE_LSB = 1;
  localparam int PKT_DATAMODE_MSB = 2;
  localparam int PKT_CTRLMODE_LSB = 3;
  localparam int PKT_CTRLMODE_MSB = 7;
  localparam int PKT_DSTADDR_LSB  = 8;
  localparam int PKT_DSTADDR_MSB  = 39;
  localparam int PKT_DATA_LSB     = 40;
  localparam int PKT_DATA_MSB     = 71;
  localparam int PKT_SRCADDR_LSB  = 72;
  localparam int PKT_SRCADDR_MSB  = 103;

  // Requester indices; also the bit position in request/grant vectors
  localparam logic [1:0] REQ_WR = 2'd0;
  localparam logic [1:0] REQ_RD = 2'd1;
  localparam logic [1:0] REQ_RR = 2'd2;

  // Arbiter FSM states
  localparam logic ST_ARB  = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  // Round-robin successor: wr -> rd -> rr -> wr
  function automatic logic [1:0] next_req(input logic [1:0] idx);
    case (idx)
      REQ_WR:  next_req = REQ_RD;
      REQ_RD:  next_req = REQ_RR;
      REQ_RR:  next_req = REQ_WR;
      default: next_req = REQ_WR;
    endcase
  endfunction

endpackage

// File: rtl/oh_arbiter_rr.sv
// -----------------------------------------------------------------------------
// oh_arbiter_rr
// 3-input round-robin arbiter with one-hot grant.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_req[2:0]  : requests (bit index = REQ_WR/REQ_RD/REQ_RR)
//   i_accept[2:0]: one-hot strobe of the requester actually accepted this
//                 cycle; only accepts move the pointer
//   o_grant[2:0]: combinational one-hot grant (0 when no request)
// -----------------------------------------------------------------------------
module oh_arbiter_rr
  import etx_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_req,
  input  logic [2:0] i_accept,
  output logic [2:0] o_grant
);

  // r_ptr holds the requester searched FIRST, i.e. the one after the last
  // accepted requester. Reset value wr makes wr the first candidate.
  logic [1:0] r_ptr;

  // Grant the first requester at or after the pointer
  always_comb begin
    o_grant = 3'b000;
    case (r_ptr)
      REQ_WR: begin
        if (i_req[0])      o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else               o_grant = 3'b000;
      end
      REQ_RD: begin
        if (i_req[1])      o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else               o_grant = 3'b000;
      end
      REQ_RR: begin
        if (i_req[2])      o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else               o_grant = 3'b000;
      end
      default: o_grant = 3'b000;
    endcase
  end

  // Pointer moves past the accepted requester; holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= REQ_WR;
    end else if (i_accept[0]) begin
      r_ptr <= next_req(REQ_WR);
    end else if (i_accept[1]) begin
      r_ptr <= next_req(REQ_RD);
    end else if (i_accept[2]) begin
      r_ptr <= next_req(REQ_RR);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/etx_arbiter.sv
// -----------------------------------------------------------------------------
// etx_arbiter
// Transmit arbiter sharing one emesh output between write (txwr), read
// request (txrd) and read response (txrr). Honors serializer stall
// (etx_wait) and remote pushback (etx_wr_wait blocks wr/rr, etx_rd_wait
// blocks rd). A bounded write-burst LOCK keeps consecutive writes together.
// Build option: ETX_ARB_FIXED_PRIO_EN -> fixed priority rr > rd > wr in ARB;
// an eligible rr also breaks a write burst.
// Parameters: PW (packet width), BURST_LEN (1..255, 1 disables LOCK).
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   txwr/txrd/txrr_access     : request valid
//   txwr/txrd/txrr_packet     : request packet
//   txwr/txrd/txrr_wait       : combinational pushback (0 = accepted now)
//   etx_access, etx_packet    : registered output
//   etx_rr                    : registered, output came from txrr
//   etx_wait                  : serializer busy, hold output
//   etx_wr_wait, etx_rd_wait  : remote pushback
// -----------------------------------------------------------------------------
module etx_arbiter
  import etx_arb_pkg::*;
#(
  parameter int PW        = 104,
  parameter int BURST_LEN = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          txwr_access,
  input  logic [PW-1:0] txwr_packet,
  output logic          txwr_wait,
  input  logic          txrd_access,
  input  logic [PW-1:0] txrd_packet,
  output logic          txrd_wait,
  input  logic          txrr_access,
  input  logic [PW-1:0] txrr_packet,
  output logic          txrr_wait,
  output logic          etx_access,
  output logic [PW-1:0] etx_packet,
  input  logic          etx_wait,
  input  logic          etx_wr_wait,
  input  logic          etx_rd_wait,
  output logic          etx_rr
);

  localparam logic [7:0] LP_BURST_LEN = 8'(BURST_LEN);
  localparam logic       LP_LOCK_EN   = (BURST_LEN > 1);

  logic          r_state;
  logic [7:0]    r_count;
  logic          w_stall;
  logic [2:0]    w_elig;
  logic [2:0]    w_rr_grant;
  logic [2:0]    w_arb_grant;
  logic [2:0]    w_grant;
  logic [2:0]    w_accept;
  logic          w_lock_wr_ok;
  logic          w_next_state;
  logic [7:0]    w_next_count;
  logic [PW-1:0] w_pkt_mux;

  assign w_stall = etx_access & etx_wait;

  // Bit order matches REQ_WR/REQ_RD/REQ_RR
  assign w_elig = {txrr_access & ~etx_wr_wait,
                   txrd_access & ~etx_rd_wait,
                   txwr_access & ~etx_wr_wait};

  oh_arbiter_rr u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_elig),
    .i_accept (w_accept),
    .o_grant  (w_rr_grant)
  );

`ifdef ETX_ARB_FIXED_PRIO_EN
  // Fixed priority rr > rd > wr replaces the round-robin result
  always_comb begin
    if (w_elig[2])      w_arb_grant = 3'b100;
    else if (w_elig[1]) w_arb_grant = 3'b010;
    else if (w_elig[0]) w_arb_grant = 3'b001;
    else                w_arb_grant = 3'b000;
  end
  // A waiting rr ends the burst so it is never starved
  assign w_lock_wr_ok = w_elig[0] & ~w_elig[2];
`else
  assign w_arb_grant  = w_rr_grant;
  assign w_lock_wr_ok = w_elig[0];
`endif

  // Grant selection and burst-lock next state
  always_comb begin
    w_grant      = 3'b000;
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      ST_ARB: begin
        w_grant = w_arb_grant;
        if (w_accept[0] && LP_LOCK_EN) begin
          w_next_state = ST_LOCK;
          w_next_count = 8'd1;
        end else begin
          w_next_state = ST_ARB;
          w_next_count = r_count;
        end
      end
      ST_LOCK: begin
        w_grant = {2'b00, w_lock_wr_ok};
        if (w_stall) begin
          w_next_state = ST_LOCK;
          w_next_count = r_count;
        end else if (w_accept[0] && (r_count + 8'd1 != LP_BURST_LEN)) begin
          w_next_state = ST_LOCK;
          w_next_count = r_count + 8'd1;
        end else begin
          // Burst full, writer idle, or remote pushback: back to ARB.
          // The last wr accept already left the pointer on rd.
          w_next_state = ST_ARB;
          w_next_count = 8'd0;
        end
      end
      default: begin
        w_grant      = 3'b000;
        w_next_state = ST_ARB;
        w_next_count = 8'd0;
      end
    endcase
  end

  assign w_accept = w_grant & {3{~w_stall}};

  // Pushback is held high throughout reset
  assign txwr_wait = reset | ~w_accept[0];
  assign txrd_wait = reset | ~w_accept[1];
  assign txrr_wait = reset | ~w_accept[2];

  // Accepted packet select
  always_comb begin
    if (w_accept[2])      w_pkt_mux = txrr_packet;
    else if (w_accept[1]) w_pkt_mux = txrd_packet;
    else                  w_pkt_mux = txwr_packet;
  end

  // Burst-lock FSM state and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_count <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  // Output register; frozen while the serializer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      etx_access <= 1'b0;
      etx_packet <= '0;
      etx_rr     <= 1'b0;
    end else if (!w_stall) begin
      etx_access <= |w_accept;
      etx_rr     <= w_accept[2];
      if (|w_accept) begin
        etx_packet <= w_pkt_mux;
      end
    end
  end

endmodule

// File: tb/tb_etx_arbiter.sv
module tb_etx_arbiter;

  localparam int PW = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          txwr_access, txrd_access, txrr_access;
  logic [PW-1:0] txwr_packet, txrd_packet, txrr_packet;
  logic          etx_wait, etx_wr_wait, etx_rd_wait;

  // index 0: BURST_LEN=8, index 1: BURST_LEN=1
  logic [1:0]    wr_wait, rd_wait, rr_wait, acc, rrf;
  logic [PW-1:0] pkt [2];

  etx_arbiter #(.PW(PW), .BURST_LEN(8)) dut8 (
    .clk(clk), .reset(reset),
    .txwr_access(txwr_access), .txwr_packet(txwr_packet), .txwr_wait(wr_wait[0]),
    .txrd_access(txrd_access), .txrd_packet(txrd_packet), .txrd_wait(rd_wait[0]),
    .txrr_access(txrr_access), .txrr_packet(txrr_packet), .txrr_wait(rr_wait[0]),
    .etx_access(acc[0]), .etx_packet(pkt[0]), .etx_wait(etx_wait),
    .etx_wr_wait(etx_wr_wait), .etx_rd_wait(etx_rd_wait), .etx_rr(rrf[0]));

  etx_arbiter #(.PW(PW), .BURST_LEN(1)) dut1 (
    .clk(clk), .reset(reset),
    .txwr_access(txwr_access), .txwr_packet(txwr_packet), .txwr_wait(wr_wait[1]),
    .txrd_access(txrd_access), .txrd_packet(txrd_packet), .txrd_wait(rd_wait[1]),
    .txrr_access(txrr_access), .txrr_packet(txrr_packet), .txrr_wait(rr_wait[1]),
    .etx_access(acc[1]), .etx_packet(pkt[1]), .etx_wait(etx_wait),
    .etx_wr_wait(etx_wr_wait), .etx_rd_wait(etx_rd_wait), .etx_rr(rrf[1]));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: one per DUT instance
  int            blen [2] = '{8, 1};
  logic          m_acc [2];
  logic [PW-1:0] m_pkt [2];
  logic          m_rr  [2];
  int            m_next [2];   // requester searched first
  bit            m_lock [2];
  int            m_cnt  [2];
  int            sq [3];       // per-class sequence number of the offered packet

  task automatic chk(input string tag, input int d, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int c, input int s);
    logic [31:0] r;
    r = $urandom;
    return {8'(c), r, 32'hC0DE0000, 32'(s)};
  endfunction

  function automatic logic [PW-1:0] pkt_of(input int c);
    case (c)
      0:       return txwr_packet;
      1:       return txrd_packet;
      default: return txrr_packet;
    endcase
  endfunction

  task automatic set_pkt(input int c);
    case (c)
      0:       txwr_packet = mk(0, sq[0]);
      1:       txrd_packet = mk(1, sq[1]);
      default: txrr_packet = mk(2, sq[2]);
    endcase
  endtask

  // Which requester wins this cycle (ignoring stall); -1 for none
  function automatic int pick(input int d);
    bit e [3];
    int order [3];
    e[0] = txwr_access && !etx_wr_wait;
    e[1] = txrd_access && !etx_rd_wait;
    e[2] = txrr_access && !etx_wr_wait;
    if (m_lock[d]) begin
`ifdef ETX_ARB_FIXED_PRIO_EN
      if (e[2]) return -1;
`endif
      return e[0] ? 0 : -1;
    end
`ifdef ETX_ARB_FIXED_PRIO_EN
    order = '{2, 1, 0};
`else
    order = '{m_next[d] % 3, (m_next[d] + 1) % 3, (m_next[d] + 2) % 3};
`endif
    for (int k = 0; k < 3; k++) if (e[order[k]]) return order[k];
    return -1;
  endfunction

  // Requester accepted this cycle; -1 for none
  function automatic int acc_idx(input int d);
    if (reset) return -1;
    if (m_acc[d] && etx_wait) return -1;
    return pick(d);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 1'b0; m_pkt[d] = '0; m_rr[d] = 1'b0;
      m_next[d] = 0; m_lock[d] = 1'b0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int a;
      if (reset) begin
        m_acc[d] = 1'b0; m_pkt[d] = '0; m_rr[d] = 1'b0;
        m_next[d] = 0; m_lock[d] = 1'b0; m_cnt[d] = 0;
      end else if (!(m_acc[d] && etx_wait)) begin
        a = pick(d);
        m_acc[d] = (a >= 0);
        m_rr[d]  = (a == 2);
        if (a >= 0) begin
          m_pkt[d]  = pkt_of(a);
          m_next[d] = (a + 1) % 3;
        end
        if (m_lock[d]) begin
          if (a == 0 && m_cnt[d] + 1 < blen[d]) m_cnt[d]++;
          else begin m_lock[d] = 1'b0; m_cnt[d] = 0; end
        end else if (a == 0 && blen[d] > 1) begin
          m_lock[d] = 1'b1; m_cnt[d] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int a;
      a = acc_idx(d);
      chk("etx_access", d, PW'(acc[d]), PW'(m_acc[d]));
      chk("etx_packet", d, pkt[d], m_pkt[d]);
      chk("etx_rr", d, PW'(rrf[d]), PW'(m_rr[d]));
      chk("txwr_wait", d, PW'(wr_wait[d]), PW'(a != 0));
      chk("txrd_wait", d, PW'(rd_wait[d]), PW'(a != 1));
      chk("txrr_wait", d, PW'(rr_wait[d]), PW'(a != 2));
    end
  endtask

  // One clock: check at negedge, model steps at posedge, then the
  // upstream offers its next packet if dut8 took the current one.
  task automatic cycle();
    int a;
    @(negedge clk);
    check_all();
    a = acc_idx(0);
    @(posedge clk);
    model_update();
    #1;
    if (a >= 0) begin
      sq[a]++;
      set_pkt(a);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    txwr_access = 1'b0; txrd_access = 1'b0; txrr_access = 1'b0;
    etx_wait = 1'b0; etx_wr_wait = 1'b0; etx_rd_wait = 1'b0;
    for (int c = 0; c < 3; c++) begin sq[c] = 0; set_pkt(c); end
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  logic [39:0] got [$];
  logic [39:0] want;
  logic [PW-1:0] held;

  initial begin
    // Reset values
    reset = 1'b1;
    model_reset();
    txwr_access = 1'b1; txrd_access = 1'b1; txrr_access = 1'b1;
    etx_wait = 1'b0; etx_wr_wait = 1'b0; etx_rd_wait = 1'b0;
    for (int c = 0; c < 3; c++) begin sq[c] = 0; set_pkt(c); end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_access", d, PW'(acc[d]), PW'(1'b0));
      chk("rst_packet", d, pkt[d], '0);
      chk("rst_waits", d, PW'({wr_wait[d], rd_wait[d], rr_wait[d]}), PW'(3'b111));
    end
    do_reset();

    // Writes only: A,B,C on consecutive cycles, then access drops
    txwr_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t1_seq", 0, PW'({pkt[0][103:96], pkt[0][31:0]}), PW'({8'd0, 32'(i)}));
    end
    txwr_access = 1'b0;
    cycle();
    chk("t1_drop", 0, PW'(acc[0]), PW'(1'b0));
    cycle();

    // All three requesting, BURST_LEN=1: wr, rd, rr, wr, rd, rr
    do_reset();
    txwr_access = 1'b1; txrd_access = 1'b1; txrr_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t2_class", 1, PW'(pkt[1][103:96]), PW'(8'(i % 3)));
      chk("t2_rr", 1, PW'(rrf[1]), PW'(i % 3 == 2));
    end

    // 12 writes with a read pending: 8 writes, 1 read, 4 writes
    do_reset();
    txwr_access = 1'b1; txrd_access = 1'b1;
    got.delete();
    for (int i = 0; i < 40 && got.size() < 13; i++) begin
      cycle();
      if (acc[0]) got.push_back({pkt[0][103:96], pkt[0][31:0]});
      if (sq[0] >= 12) txwr_access = 1'b0;
    end
    chk("t3_len", 0, PW'(got.size()), PW'(13));
    for (int i = 0; i < 13 && i < got.size(); i++) begin
      if (i < 8)       want = {8'd0, 32'(i)};
      else if (i == 8) want = {8'd1, 32'd0};
      else             want = {8'd0, 32'(i - 1)};
      chk("t3_order", 0, PW'(got[i]), PW'(want));
    end
    txrd_access = 1'b0;
    txwr_access = 1'b0;
    cycle();

    // Serializer stall mid-burst
    do_reset();
    txwr_access = 1'b1;
    repeat (3) cycle();
    held = pkt[0];
    etx_wait = 1'b1;
    repeat (3) begin
      cycle();
      chk("t4_hold", 0, pkt[0], held);
    end
    etx_wait = 1'b0;
    cycle();
    chk("t4_resume", 0, PW'(pkt[0][31:0]), PW'(32'd3));
    repeat (6) cycle();
    txwr_access = 1'b0;
    cycle();

    // Remote write pushback: only rd passes
    do_reset();
    txwr_access = 1'b1; txrd_access = 1'b1; txrr_access = 1'b1;
    etx_wr_wait = 1'b1;
    repeat (4) begin
      cycle();
      chk("t5_acc", 0, PW'(acc[0]), PW'(1'b1));
      chk("t5_class", 0, PW'(pkt[0][103:96]), PW'(8'd1));
      chk("t5_rr", 0, PW'(rrf[0]), PW'(1'b0));
    end
    etx_wr_wait = 1'b0;
    cycle();
    chk("t5_resume", 0, PW'(pkt[0][103:96]), PW'(8'd2));
    chk("t5_rr_set", 0, PW'(rrf[0]), PW'(1'b1));
    repeat (3) cycle();

    // Reset in the middle of a burst
    do_reset();
    txwr_access = 1'b1; txrd_access = 1'b1;
    repeat (5) cycle();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t6_acc", d, PW'(acc[d]), PW'(1'b0));
      chk("t6_waits", d, PW'({wr_wait[d], rd_wait[d], rr_wait[d]}), PW'(3'b111));
    end
    model_reset();
    cycle();
    reset = 1'b0;
    txrr_access = 1'b1;
    cycle();
    chk("t6_first", 0, PW'(pkt[0][103:96]), PW'(8'd0));
    chk("t6_first", 1, PW'(pkt[1][103:96]), PW'(8'd0));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      txwr_access = ($urandom_range(9) < 7);
      txrd_access = ($urandom_range(9) < 5);
      txrr_access = ($urandom_range(9) < 4);
      etx_wait    = ($urandom_range(3) == 0);
      etx_wr_wait = ($urandom_range(6) == 0);
      etx_rd_wait = ($urandom_range(6) == 0);
      if ($urandom_range(99) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      cycle();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
